mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/riscv_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter_starve_cnt.sv | 44 ++++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared types and defaults for the memory arbiter that sits between the
// fetch and MEM stages and the single-port memory.
package riscv_pkg;

    localparam int MAX_CONSEC_DEF = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY_IF = 3'd1,
        BUSY_DM = 3'd2,
        RESP_IF = 3'd3,
        RESP_DM = 3'd4
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the arbiter: fetch port, data port and shared-memory port.
// Handshake: a requester raises *_req and holds it with stable fields until the
// one-cycle *_ready pulse; the arbiter holds mem_valid with stable fields until
// the one-cycle mem_ack pulse.
interface mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        stall_f;
    logic        stall_m;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, dm_rdata, dm_ready,
        output mem_valid, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
        input  mem_valid, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

endinterface

// File: rtl/mem_arbiter_starve_cnt.sv
// Counts back-to-back data grants taken while a fetch is waiting, so the
// arbiter can force a fetch grant once the limit is reached.
module arb_starve_cnt #(
    parameter int MAX_CONSEC = riscv_pkg::MAX_CONSEC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       grant_dm,
    input  logic       grant_if,
    input  logic       if_req,
    output logic [2:0] consec_o,
    output logic       starve_o
);

    localparam logic [2:0] MAX_C = 3'(MAX_CONSEC);

    logic [2:0] consec_q;
    logic [2:0] consec_d;

    always_comb begin
        consec_d = consec_q;
        if (grant_if) begin
            consec_d = 3'd0;
        end else if (grant_dm) begin
            if (!if_req) begin
                consec_d = 3'd0;
            end else if (consec_q < MAX_C) begin
                consec_d = consec_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            consec_q <= 3'd0;
        end else begin
            consec_q <= consec_d;
        end
    end

    assign consec_o = consec_q;
    assign starve_o = (consec_q >= MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a single-port memory: data requests win unless a
// waiting fetch has been passed over MAX_CONSEC times in a row.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int MAX_CONSEC = MAX_CONSEC_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   bus,
    output arb_state_e     state_o,
    output logic [2:0]     consec_o
);

    arb_state_e  state_q, state_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        grant_if, grant_dm;
    logic        starve;

    arb_starve_cnt #(.MAX_CONSEC(MAX_CONSEC)) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .grant_dm (grant_dm),
        .grant_if (grant_if),
        .if_req   (bus.if_req),
        .consec_o (consec_o),
        .starve_o (starve)
    );

    always_comb begin
        state_d     = state_q;
        grant_if    = 1'b0;
        grant_dm    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.dm_req && (!bus.if_req || !starve)) begin
                    grant_dm    = 1'b1;
                    state_d     = BUSY_DM;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                end else if (bus.if_req) begin
                    grant_if    = 1'b1;
                    state_d     = BUSY_IF;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                end
            end
            BUSY_IF: begin
                if (bus.mem_ack) begin
                    state_d    = RESP_IF;
                    if_rdata_d = bus.mem_rdata;
                end
            end
            BUSY_DM: begin
                if (bus.mem_ack) begin
                    state_d = RESP_DM;
                    // Stores complete without disturbing the last load value.
                    if (!mem_we_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                end
            end
            RESP_IF, RESP_DM: state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            dm_rdata_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign bus.mem_valid = (state_q == BUSY_IF) || (state_q == BUSY_DM);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ready  = (state_q == RESP_IF);
    assign bus.dm_ready  = (state_q == RESP_DM);
    assign bus.stall_f   = bus.if_req & ~bus.if_ready;
    assign bus.stall_m   = bus.dm_req & ~bus.dm_ready;
    assign state_o       = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, data/fetch contention, store,
// starvation limit and asynchronous reset in the middle of a transaction.
module tb_mem_arbiter;
  import riscv_pkg::*;

  logic       clk;
  logic       rst_n;
  arb_state_e state_dbg;
  logic [2:0] consec_dbg;
  int         n_cmp;
  int         n_err;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_CONSEC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .state_o  (state_dbg),
    .consec_o (consec_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'd0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 32'd0;
    bus.dm_wdata  = 32'd0;
    bus.mem_rdata = 32'd0;
    bus.mem_ack   = 1'b0;
  endtask

  // pattern table for the starvation run: 1 = fetch grant expected
  logic [9:0] fetch_pat;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive_idle();

    // reset state
    neg();
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_dm_ready", 32'(bus.dm_ready), 32'd0);
    check("rst_consec", 32'(consec_dbg), 32'd0);
    neg();
    rst_n = 1'b1;

    // fetch only, ack two cycles after mem_valid rises
    neg();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    #1;
    check("f_stall_pre", 32'(bus.stall_f), 32'd1);
    neg();
    check("f_state_busy", 32'(state_dbg), 32'(BUSY_IF));
    check("f_mem_valid", 32'(bus.mem_valid), 32'd1);
    check("f_mem_we", 32'(bus.mem_we), 32'd0);
    check("f_mem_addr", bus.mem_addr, 32'h100);
    check("f_stall_busy", 32'(bus.stall_f), 32'd1);
    neg();
    check("f_mem_valid_hold", 32'(bus.mem_valid), 32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00500093;
    neg();
    bus.mem_ack = 1'b0;
    check("f_if_ready", 32'(bus.if_ready), 32'd1);
    check("f_if_rdata", bus.if_rdata, 32'h00500093);
    check("f_stall_done", 32'(bus.stall_f), 32'd0);
    check("f_mem_valid_resp", 32'(bus.mem_valid), 32'd0);
    bus.if_req = 1'b0;
    neg();
    check("f_back_idle", 32'(state_dbg), 32'(IDLE));
    check("f_if_ready_off", 32'(bus.if_ready), 32'd0);

    // simultaneous fetch and load: data first
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h104;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h2000;
    neg();
    check("c_state_dm", 32'(state_dbg), 32'(BUSY_DM));
    check("c_mem_addr", bus.mem_addr, 32'h2000);
    check("c_consec", 32'(consec_dbg), 32'd1);
    check("c_stall_m", 32'(bus.stall_m), 32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    neg();
    bus.mem_ack = 1'b0;
    check("c_dm_ready", 32'(bus.dm_ready), 32'd1);
    check("c_dm_rdata", bus.dm_rdata, 32'hDEADBEEF);
    check("c_stall_f", 32'(bus.stall_f), 32'd1);
    bus.dm_req = 1'b0;
    neg();
    check("c_resp_no_grant", 32'(state_dbg), 32'(IDLE));
    neg();
    check("c_state_if", 32'(state_dbg), 32'(BUSY_IF));
    check("c_if_addr", bus.mem_addr, 32'h104);
    check("c_consec_clr", 32'(consec_dbg), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00000013;
    neg();
    bus.mem_ack = 1'b0;
    check("c_if_rdata", bus.if_rdata, 32'h00000013);
    bus.if_req = 1'b0;
    neg();

    // store: fields stable until ack, load data untouched
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h2004;
    bus.dm_wdata = 32'h12345678;
    neg();
    check("s_mem_we", 32'(bus.mem_we), 32'd1);
    check("s_mem_addr", bus.mem_addr, 32'h2004);
    check("s_mem_wdata", bus.mem_wdata, 32'h12345678);
    bus.dm_addr  = 32'hFFFF_0000;
    bus.dm_wdata = 32'h0;
    neg();
    check("s_addr_stable", bus.mem_addr, 32'h2004);
    check("s_wdata_stable", bus.mem_wdata, 32'h12345678);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    neg();
    bus.mem_ack = 1'b0;
    check("s_dm_ready", 32'(bus.dm_ready), 32'd1);
    check("s_dm_rdata_kept", bus.dm_rdata, 32'hDEADBEEF);
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
    neg();

    // continuous contention: four data grants, then one fetch
    fetch_pat   = 10'b10000_10000;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h200;
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h3000;
    for (int k = 0; k < 10; k++) begin
      int wait_cyc;
      wait_cyc = 0;
      while (!bus.mem_valid && wait_cyc < 20) begin
        neg();
        wait_cyc++;
      end
      check($sformatf("st_grant_seen_%0d", k), 32'(bus.mem_valid), 32'd1);
      check($sformatf("st_grant_addr_%0d", k), bus.mem_addr,
            fetch_pat[k] ? 32'h200 : 32'h3000);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'(k + 1);
      neg();
      bus.mem_ack = 1'b0;
      if (fetch_pat[k]) begin
        check($sformatf("st_if_ready_%0d", k), 32'(bus.if_ready), 32'd1);
        check($sformatf("st_if_rdata_%0d", k), bus.if_rdata, 32'(k + 1));
      end else begin
        check($sformatf("st_dm_ready_%0d", k), 32'(bus.dm_ready), 32'd1);
        check($sformatf("st_dm_rdata_%0d", k), bus.dm_rdata, 32'(k + 1));
      end
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    neg();
    check("st_consec_end", 32'(consec_dbg), 32'd0);

    // reset asserted mid BUSY_DM, then a late ack
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h2008;
    neg();
    check("r_busy", 32'(bus.mem_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_mem_valid_now", 32'(bus.mem_valid), 32'd0);
    check("r_state_now", 32'(state_dbg), 32'(IDLE));
    check("r_mem_addr_now", bus.mem_addr, 32'd0);
    check("r_dm_rdata_now", bus.dm_rdata, 32'd0);
    check("r_if_rdata_now", bus.if_rdata, 32'd0);
    bus.dm_req = 1'b0;
    neg();
    rst_n         = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD0BAD;
    neg();
    bus.mem_ack = 1'b0;
    check("r_late_ack_state", 32'(state_dbg), 32'(IDLE));
    check("r_late_ack_ready", 32'(bus.dm_ready), 32'd0);
    check("r_late_ack_rdata", bus.dm_rdata, 32'd0);

    // first grant right after reset
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    neg();
    check("r_first_grant", 32'(state_dbg), 32'(BUSY_IF));
    check("r_first_addr", bus.mem_addr, 32'h300);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00A00113;
    neg();
    bus.mem_ack = 1'b0;
    check("r_first_ready", 32'(bus.if_ready), 32'd1);
    bus.if_req = 1'b0;
    neg();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
